// File: rtl/ros_measure_sequencer.sv
// Round sequencer for the ring-oscillator measurement path: clear, gate, latch,
// then serialise each enabled oscillator count as a {HEADER, count} frame, MSB first.
module ros_measure_sequencer #(
  parameter int         COUNTER_LENGTH = 20,
  parameter int         NUM_ROS        = 3,
  parameter int         GATE_WIDTH     = 16,
  parameter int         SYNC_DELAY     = 4,
  parameter logic [3:0] HEADER         = 4'b1010
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic                              i_continuous,
  input  logic [NUM_ROS-1:0]                i_ros_mask,
  input  logic [GATE_WIDTH-1:0]             i_gate_cycles,
  input  logic [NUM_ROS*COUNTER_LENGTH-1:0] i_cycle_count_flat,
  output logic                              o_ctr_reset,
  output logic                              o_latch_counter,
  output logic [1:0]                        o_counter_select,
  output logic                              o_ser_data,
  output logic                              o_ser_valid,
  output logic                              o_frame_start,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int FRAME_LEN = COUNTER_LENGTH + 4;
  localparam int CNT_W     = (GATE_WIDTH > 8) ? GATE_WIDTH : 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_LATCH  = 3'd3,
    S_SETTLE = 3'd4,
    S_LOAD   = 3'd5,
    S_SHIFT  = 3'd6
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_next;
  logic [NUM_ROS-1:0]        r_mask;
  logic [NUM_ROS-1:0]        w_mask_next;
  logic [GATE_WIDTH-1:0]     r_gate;
  logic [GATE_WIDTH-1:0]     w_gate_next;
  logic [GATE_WIDTH-1:0]     w_live_gate;
  logic [1:0]                r_sel;
  logic [1:0]                w_sel_next;
  logic [FRAME_LEN-1:0]      r_shreg;
  logic [FRAME_LEN-1:0]      w_shreg_next;
  logic [COUNTER_LENGTH-1:0] w_sel_count;
  logic [2:0]                w_lowest;
  logic [2:0]                w_higher;
  logic                      w_done_next;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] find_set(input logic [NUM_ROS-1:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = NUM_ROS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  assign o_counter_select = r_sel;
  assign o_ser_data       = r_shreg[FRAME_LEN-1];
  assign w_live_gate      = (i_gate_cycles == {GATE_WIDTH{1'b0}}) ? GATE_WIDTH'(1) : i_gate_cycles;
  assign w_lowest         = find_set(r_mask, 3'd0);
  assign w_higher         = find_set(r_mask, {1'b0, r_sel} + 3'd1);

  // Count slice of the currently selected oscillator.
  always_comb begin
    w_sel_count = {COUNTER_LENGTH{1'b0}};
    for (int i = 0; i < NUM_ROS; i++) begin
      if (r_sel == 2'(i)) begin
        w_sel_count = i_cycle_count_flat[i*COUNTER_LENGTH +: COUNTER_LENGTH];
      end else begin
        w_sel_count = w_sel_count;
      end
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_mask_next  = r_mask;
    w_gate_next  = r_gate;
    w_sel_next   = r_sel;
    w_shreg_next = r_shreg;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && (i_ros_mask != {NUM_ROS{1'b0}})) begin
          w_next_state = S_CLEAR;
          w_mask_next  = i_ros_mask;
          w_gate_next  = w_live_gate;
          w_cnt_next   = CNT_W'(SYNC_DELAY - 1);
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (r_cnt == CNT_W'(0)) begin
          w_next_state = S_GATE;
          w_cnt_next   = CNT_W'(r_gate) - CNT_W'(1);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_GATE: begin
        if (r_cnt == CNT_W'(0)) begin
          w_next_state = S_LATCH;
          w_cnt_next   = CNT_W'(SYNC_DELAY - 1);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (r_cnt == CNT_W'(0)) begin
          w_next_state = S_SETTLE;
          w_cnt_next   = CNT_W'(SYNC_DELAY - 1);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (r_cnt == CNT_W'(0)) begin
          w_next_state = S_LOAD;
          w_sel_next   = w_lowest[1:0];
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_LOAD: begin
        w_next_state = S_SHIFT;
        w_shreg_next = {HEADER, w_sel_count};
        w_cnt_next   = CNT_W'(FRAME_LEN - 1);
      end
      S_SHIFT: begin
        // Zero-filling shift leaves the register clear once the frame is out.
        w_shreg_next = r_shreg << 1;
        if (r_cnt != CNT_W'(0)) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else if (w_higher[2]) begin
          w_next_state = S_LOAD;
          w_sel_next   = w_higher[1:0];
        end else if (i_continuous) begin
          if (i_ros_mask != {NUM_ROS{1'b0}}) begin
            w_next_state = S_CLEAR;
            w_mask_next  = i_ros_mask;
            w_gate_next  = w_live_gate;
            w_cnt_next   = CNT_W'(SYNC_DELAY - 1);
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_state = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered control outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= CNT_W'(0);
      r_mask          <= {NUM_ROS{1'b0}};
      r_gate          <= GATE_WIDTH'(1);
      r_sel           <= 2'd0;
      r_shreg         <= {FRAME_LEN{1'b0}};
      o_ctr_reset     <= 1'b1;
      o_latch_counter <= 1'b0;
      o_ser_valid     <= 1'b0;
      o_frame_start   <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_cnt           <= w_cnt_next;
      r_mask          <= w_mask_next;
      r_gate          <= w_gate_next;
      r_sel           <= w_sel_next;
      r_shreg         <= w_shreg_next;
      o_ctr_reset     <= (w_next_state == S_IDLE) || (w_next_state == S_CLEAR);
      o_latch_counter <= (w_next_state == S_LATCH);
      o_ser_valid     <= (w_next_state == S_SHIFT);
      o_frame_start   <= (r_state == S_LOAD);
      o_busy          <= (w_next_state != S_IDLE);
      o_done          <= w_done_next;
    end
  end

endmodule

// File: tb/tb_ros_measure_sequencer.sv
// Scoreboard bench for ros_measure_sequencer: expected frame bits are queued at
// stimulus time and compared by a monitor whenever ser_valid is high.
module tb_ros_measure_sequencer;

  localparam int CL = 20;
  localparam int NR = 3;
  localparam int GW = 16;
  localparam int SD = 4;
  localparam int FL = CL + 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             continuous;
  logic [NR-1:0]    ros_mask;
  logic [GW-1:0]    gate_cycles;
  logic [NR*CL-1:0] flat;
  logic             ctr_reset, latch_counter, ser_data, ser_valid, frame_start, busy, done;
  logic [1:0]       counter_select;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       d;
    logic [1:0] sel;
    logic       fs;
  } bit_t;
  bit_t sb[$];

  always #5 clk = ~clk;

  ros_measure_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_continuous(continuous),
    .i_ros_mask(ros_mask), .i_gate_cycles(gate_cycles), .i_cycle_count_flat(flat),
    .o_ctr_reset(ctr_reset), .o_latch_counter(latch_counter), .o_counter_select(counter_select),
    .o_ser_data(ser_data), .o_ser_valid(ser_valid), .o_frame_start(frame_start),
    .o_busy(busy), .o_done(done)
  );

  // Scoreboard monitor: every valid serial bit is checked against the queue head.
  always @(negedge clk) begin
    if (ser_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra_bit: got data=%b sel=%0d, required no valid bit", ser_data, counter_select);
      end else begin
        bit_t e;
        e = sb.pop_front();
        if ({ser_data, counter_select, frame_start} !== {e.d, e.sel, e.fs}) begin
          bad++;
          $display("FAIL sb_bit: got data=%b sel=%0d fs=%b, required data=%b sel=%0d fs=%b",
                   ser_data, counter_select, frame_start, e.d, e.sel, e.fs);
        end
      end
    end
  end

  task automatic push_frames(input logic [NR-1:0] m);
    logic [FL-1:0] f;
    logic [3:0]    hdr;
    bit_t          e;
    hdr = 4'b1010;
    for (int r = 0; r < NR; r++) begin
      if (m[r]) begin
        f = {hdr, flat[r*CL +: CL]};
        for (int b = FL - 1; b >= 0; b--) begin
          e.d   = f[b];
          e.sel = 2'(r);
          e.fs  = (b == FL - 1);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic run_round(input int budget, input bit drop_cont, input bit toggle_start,
                           output int busy_c, output int gate_c, output int latch_c,
                           output int done_c, output int valid_c, output int gap_c, output bit tmo);
    int   cyc;
    int   falls;
    bit   seen_busy, seen_valid, seen_latch;
    logic prev_cr;
    busy_c = 0; gate_c = 0; latch_c = 0; done_c = 0; valid_c = 0; gap_c = 0; tmo = 1'b0;
    cyc = 0; falls = 0; seen_busy = 1'b0; seen_valid = 1'b0; seen_latch = 1'b0; prev_cr = 1'b1;
    start = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (toggle_start && cyc < 40) start = ~start;
      else start = 1'b0;
      if (toggle_start && cyc == 5) begin
        ros_mask    = 3'b111;
        gate_cycles = 16'd5;
      end
      if (busy === 1'b1) begin
        seen_busy = 1'b1;
        busy_c++;
      end
      if (done === 1'b1) done_c++;
      if (latch_counter === 1'b1) begin
        seen_latch = 1'b1;
        if (valid_c == 0) latch_c++;
      end
      if (!seen_latch && busy === 1'b1 && ctr_reset === 1'b0 && latch_counter === 1'b0) gate_c++;
      if (ser_valid === 1'b1) begin
        seen_valid = 1'b1;
        valid_c++;
      end else if (seen_valid && busy === 1'b1) begin
        gap_c++;
      end
      if (prev_cr === 1'b1 && ctr_reset === 1'b0 && busy === 1'b1) falls++;
      if (drop_cont && falls == 2) continuous = 1'b0;
      prev_cr = ctr_reset;
      if (seen_busy && busy === 1'b0) break;
      if (cyc >= budget) begin
        tmo = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (done === 1'b1) done_c++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; continuous = 1'b0; ros_mask = 3'b001; gate_cycles = 16'd10;
    flat = {20'hC3C3C, 20'h0F0F0, 20'h5A5A5};
    repeat (3) @(negedge clk);
    total++; if (ctr_reset !== 1'b1) begin bad++; $display("FAIL rst_ctr_reset: got %b required 1", ctr_reset); end
    total++; if (latch_counter !== 1'b0) begin bad++; $display("FAIL rst_latch: got %b required 0", latch_counter); end
    total++; if (counter_select !== 2'd0) begin bad++; $display("FAIL rst_sel: got %0d required 0", counter_select); end
    total++; if ({ser_data, ser_valid, frame_start} !== 3'b000) begin bad++; $display("FAIL rst_ser: got %b required 000", {ser_data, ser_valid, frame_start}); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_busy_done: got %b required 00", {busy, done}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || ctr_reset !== 1'b1) begin bad++; $display("FAIL rst_idle_hold: got busy=%b ctr_reset=%b required 0/1", busy, ctr_reset); end
  endtask

  task automatic test_single();
    int b, g, l, d, v, gp; bit t;
    ros_mask = 3'b001; gate_cycles = 16'd100;
    push_frames(3'b001);
    run_round(500, 1'b0, 1'b0, b, g, l, d, v, gp, t);
    total++; if (t) begin bad++; $display("FAIL t1_timeout: got timeout required round end"); end
    total++; if (g != 100) begin bad++; $display("FAIL t1_gate_len: got %0d required 100", g); end
    total++; if (l != SD) begin bad++; $display("FAIL t1_latch_len: got %0d required %0d", l, SD); end
    total++; if (b != 3*SD + 100 + FL + 1) begin bad++; $display("FAIL t1_round_len: got %0d required %0d", b, 3*SD + 100 + FL + 1); end
    total++; if (v != FL) begin bad++; $display("FAIL t1_valid_bits: got %0d required %0d", v, FL); end
    total++; if (d != 1) begin bad++; $display("FAIL t1_done_pulses: got %0d required 1", d); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end: got %b required 0", busy); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL t1_sb_left: got %0d required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_two_frames();
    int b, g, l, d, v, gp; bit t;
    flat = {20'hABCDE, 20'h77777, 20'h12345};
    ros_mask = 3'b101; gate_cycles = 16'd20;
    push_frames(3'b101);
    run_round(500, 1'b0, 1'b0, b, g, l, d, v, gp, t);
    total++; if (t) begin bad++; $display("FAIL t2_timeout: got timeout required round end"); end
    total++; if (b != 4*3 + 20 + 2*25) begin bad++; $display("FAIL t2_round_len: got %0d required %0d", b, 4*3 + 20 + 2*25); end
    total++; if (v != 2*FL) begin bad++; $display("FAIL t2_valid_bits: got %0d required %0d", v, 2*FL); end
    total++; if (gp != 1) begin bad++; $display("FAIL t2_load_gap: got %0d required 1", gp); end
    total++; if (d != 1) begin bad++; $display("FAIL t2_done_pulses: got %0d required 1", d); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL t2_sb_left: got %0d required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_continuous();
    int b, g, l, d, v, gp; bit t;
    flat = {20'h13579, 20'h2468A, 20'hFEDCB};
    ros_mask = 3'b111; gate_cycles = 16'd10; continuous = 1'b1;
    push_frames(3'b111);
    push_frames(3'b111);
    run_round(1000, 1'b1, 1'b0, b, g, l, d, v, gp, t);
    continuous = 1'b0;
    total++; if (t) begin bad++; $display("FAIL t3_timeout: got timeout required round end"); end
    total++; if (b != 2*(3*SD + 10 + 3*(FL+1))) begin bad++; $display("FAIL t3_busy_len: got %0d required %0d", b, 2*(3*SD + 10 + 3*(FL+1))); end
    total++; if (g != 10) begin bad++; $display("FAIL t3_gate_len: got %0d required 10", g); end
    total++; if (v != 6*FL) begin bad++; $display("FAIL t3_valid_bits: got %0d required %0d", v, 6*FL); end
    total++; if (d != 1) begin bad++; $display("FAIL t3_done_pulses: got %0d required 1", d); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL t3_sb_left: got %0d required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_mid_shift();
    int v;
    int d;
    int cyc;
    ros_mask = 3'b001; gate_cycles = 16'd10;
    push_frames(3'b001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    v = 0; cyc = 0;
    while (v < 10 && cyc < 200) begin
      if (ser_valid === 1'b1) v++;
      if (v < 10) begin
        @(negedge clk);
        cyc++;
      end
    end
    total++; if (v != 10) begin bad++; $display("FAIL t4_reach_bit10: got %0d bits required 10", v); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({ser_valid, ctr_reset, busy, done} !== 4'b0100) begin bad++; $display("FAIL t4_abort: got valid/cr/busy/done=%b required 0100", {ser_valid, ctr_reset, busy, done}); end
    sb.delete();
    reset = 1'b0;
    v = 0; d = 0;
    repeat (40) begin
      @(negedge clk);
      if (ser_valid === 1'b1) v++;
      if (done === 1'b1 || busy === 1'b1) d++;
    end
    total++; if (v != 0 || d != 0) begin bad++; $display("FAIL t4_quiet: got valid=%0d busy_or_done=%0d required 0/0", v, d); end
  endtask

  task automatic test_gate_zero();
    int b, g, l, d, v, gp; bit t;
    ros_mask = 3'b010; gate_cycles = 16'd0;
    push_frames(3'b010);
    run_round(500, 1'b0, 1'b0, b, g, l, d, v, gp, t);
    total++; if (g != 1) begin bad++; $display("FAIL t5_gate_len: got %0d required 1", g); end
    total++; if (b != 3*SD + 1 + FL + 1) begin bad++; $display("FAIL t5_round_len: got %0d required %0d", b, 3*SD + 1 + FL + 1); end
    total++; if (sb.size() != 0 || t) begin bad++; $display("FAIL t5_sb_left: got %0d timeout=%b required 0/0", sb.size(), t); end
    sb.delete();
  endtask

  task automatic test_mask_zero();
    int bc;
    ros_mask = 3'b000; gate_cycles = 16'd5; start = 1'b1;
    bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || ctr_reset !== 1'b1) bc++;
    end
    start = 1'b0;
    total++; if (bc != 0) begin bad++; $display("FAIL t6_mask_zero: got %0d non-idle cycles required 0", bc); end
  endtask

  task automatic test_start_while_busy();
    int b, g, l, d, v, gp; bit t;
    ros_mask = 3'b001; gate_cycles = 16'd30;
    push_frames(3'b001);
    run_round(500, 1'b0, 1'b1, b, g, l, d, v, gp, t);
    ros_mask = 3'b001;
    total++; if (b != 3*SD + 30 + FL + 1) begin bad++; $display("FAIL t6b_round_len: got %0d required %0d", b, 3*SD + 30 + FL + 1); end
    total++; if (v != FL || d != 1) begin bad++; $display("FAIL t6b_frames: got bits=%0d done=%0d required %0d/1", v, d, FL); end
    total++; if (sb.size() != 0 || t) begin bad++; $display("FAIL t6b_sb_left: got %0d timeout=%b required 0/0", sb.size(), t); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_frames();
    test_continuous();
    test_reset_mid_shift();
    test_gate_zero();
    test_mask_zero();
    test_start_while_busy();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
